// File: rtl/pipelined_rca_adder_if.sv
// Valid/ready operand and result bus for pipelined_rca_adder.
// With PIPE_RCA_SUB_EN defined the bus also carries the Sub select.
interface pipelined_rca_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
`ifdef PIPE_RCA_SUB_EN
    logic             Sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             V;

`ifdef PIPE_RCA_SUB_EN
    modport master (
        output in_valid, A, B, C_in, Sub, out_ready,
        input  in_ready, out_valid, S, C_out, V
    );
    modport slave (
        input  in_valid, A, B, C_in, Sub, out_ready,
        output in_ready, out_valid, S, C_out, V
    );
`else
    modport master (
        output in_valid, A, B, C_in, out_ready,
        input  in_ready, out_valid, S, C_out, V
    );
    modport slave (
        input  in_valid, A, B, C_in, out_ready,
        output in_ready, out_valid, S, C_out, V
    );
`endif
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: one SEG-bit segment per stage, carry registered between stages.
// Define PIPE_RCA_SUB_EN to add the Sub input (A - B - C_in computed as A + ~B + ~C_in).
module pipelined_rca_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_rca_adder_if.slave bus
);
    localparam int SEG_NZ = (SEG < 1) ? 1 : SEG;
    localparam int STAGES = (WIDTH / SEG_NZ < 1) ? 1 : WIDTH / SEG_NZ;

    if ((SEG < 1) || (WIDTH % SEG_NZ != 0)) begin : g_bad_cfg
        $error("pipelined_rca_adder: WIDTH must be a nonzero multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

`ifdef PIPE_RCA_SUB_EN
    // Subtraction is folded into the operand at entry, so the inverted B travels down the skew.
    assign b_eff   = bus.Sub ? ~bus.B : bus.B;
    assign cin_eff = bus.C_in ^ bus.Sub;
`else
    assign b_eff   = bus.B;
    assign cin_eff = bus.C_in;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG_NZ;
        localparam int HI = LO + SEG_NZ - 1;

        logic              vld_d;
        logic              vld_q;
        logic              ld;
        logic [SEG_NZ-1:0] a_seg;
        logic [SEG_NZ-1:0] b_seg;
        logic [SEG_NZ-1:0] s_seg;
        logic [SEG_NZ:0]   c;
        logic [HI:0]       sum_d;
        logic [HI:0]       sum_q;
        logic              carry_q;

        if (k == 0) begin : g_src
            assign vld_d = bus.in_valid;
            assign a_seg = bus.A[HI:LO];
            assign b_seg = b_eff[HI:LO];
            assign c[0]  = cin_eff;
            assign sum_d = s_seg;
        end else begin : g_src
            assign vld_d = g_stg[k-1].vld_q;
            assign a_seg = g_stg[k-1].g_hi.a_hi_q[HI:LO];
            assign b_seg = g_stg[k-1].g_hi.b_hi_q[HI:LO];
            assign c[0]  = g_stg[k-1].carry_q;
            assign sum_d = {s_seg, g_stg[k-1].sum_q};
        end

        for (genvar i = 0; i < SEG_NZ; i++) begin : g_fa
            assign s_seg[i]  = a_seg[i] ^ b_seg[i] ^ c[i];
            assign c[i+1]    = (a_seg[i] & b_seg[i]) | (c[i] & (a_seg[i] ^ b_seg[i]));
        end

        // Data only loads for valid slots so the outputs keep the last real result across bubbles.
        assign ld = adv & vld_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                if (adv) vld_q <= vld_d;
                if (ld) begin
                    sum_q   <= sum_d;
                    carry_q <= c[SEG_NZ];
                end
            end
        end

        if (k < STAGES - 1) begin : g_hi
            logic [WIDTH-1:HI+1] a_hi_q;
            logic [WIDTH-1:HI+1] b_hi_q;
            logic [WIDTH-1:HI+1] a_hi_d;
            logic [WIDTH-1:HI+1] b_hi_d;

            if (k == 0) begin : g_hsrc
                assign a_hi_d = bus.A[WIDTH-1:HI+1];
                assign b_hi_d = b_eff[WIDTH-1:HI+1];
            end else begin : g_hsrc
                assign a_hi_d = g_stg[k-1].g_hi.a_hi_q[WIDTH-1:HI+1];
                assign b_hi_d = g_stg[k-1].g_hi.b_hi_q[WIDTH-1:HI+1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (ld) begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic v_q;

            // Overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  v_q <= 1'b0;
                else if (ld) v_q <= c[SEG_NZ-1] ^ c[SEG_NZ];
            end
        end
    end

    assign bus.out_valid = g_stg[STAGES-1].vld_q;
    assign bus.S         = g_stg[STAGES-1].sum_q;
    assign bus.C_out     = g_stg[STAGES-1].carry_q;
    assign bus.V         = g_stg[STAGES-1].g_last.v_q;
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed and random checks of pipelined_rca_adder at WIDTH=16, SEG=4.
module tb_pipelined_rca_adder;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    pipelined_rca_adder_if #(.WIDTH(16)) bus();

    pipelined_rca_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    // Sends one op into an empty pipe and waits (bounded) for its result; lat = -1 on timeout.
    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           output logic [15:0] s, output logic co, output logic v, output int lat);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.C_in = cin; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = -1; s = 16'h0; co = 1'b0; v = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = n; s = bus.S; co = bus.C_out; v = bus.V;
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.A = 16'h0; bus.B = 16'h0; bus.C_in = 1'b0; bus.out_ready = 1'b0;
`ifdef PIPE_RCA_SUB_EN
        bus.Sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_chk++; if (bus.S !== 16'h0) begin n_fail++; $display("FAIL reset_S: got %h want 0000", bus.S); end
        n_chk++; if (bus.C_out !== 1'b0) begin n_fail++; $display("FAIL reset_C_out: got %b want 0", bus.C_out); end
        n_chk++; if (bus.V !== 1'b0) begin n_fail++; $display("FAIL reset_V: got %b want 0", bus.V); end
        rst_n = 1'b1;
        #1;
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_carry_wrap();
        logic [15:0] s; logic co, v; int lat;
        run_one(16'hFFFF, 16'h0001, 1'b0, s, co, v, lat);
        n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL wrap_latency: got %0d want 4", lat); end
        n_chk++; if (s !== 16'h0000) begin n_fail++; $display("FAIL wrap_S: got %h want 0000", s); end
        n_chk++; if (co !== 1'b1) begin n_fail++; $display("FAIL wrap_C_out: got %b want 1", co); end
        n_chk++; if (v !== 1'b0) begin n_fail++; $display("FAIL wrap_V: got %b want 0", v); end
    endtask

    task automatic test_overflow();
        logic [15:0] s; logic co, v; int lat;
        run_one(16'h7FFF, 16'h0001, 1'b1, s, co, v, lat);
        n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL ovf_latency: got %0d want 4", lat); end
        n_chk++; if (s !== 16'h8001) begin n_fail++; $display("FAIL ovf_S: got %h want 8001", s); end
        n_chk++; if (co !== 1'b0) begin n_fail++; $display("FAIL ovf_C_out: got %b want 0", co); end
        n_chk++; if (v !== 1'b1) begin n_fail++; $display("FAIL ovf_V: got %b want 1", v); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, recv = 0, extra = 0;
        logic tin, tout;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < 8);
            bus.A         = 16'(sent);
            bus.B         = 16'(100 * sent);
            bus.C_in      = 1'b0;
            bus.out_ready = !(cyc >= 6 && cyc < 9);
            #1;
            if (cyc >= 6 && cyc < 9) begin
                n_chk++;
                if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready cyc %0d: got %b want 0", cyc, bus.in_ready); end
            end
            tin  = bus.in_valid & bus.in_ready;
            tout = bus.out_valid & bus.out_ready;
            if (tout) begin
                n_chk++;
                if ({bus.V, bus.C_out, bus.S} !== {2'b00, 16'(101 * recv)})
                    begin n_fail++; $display("FAIL b2b_result #%0d: got V=%b C=%b S=%h want V=0 C=0 S=%h", recv, bus.V, bus.C_out, bus.S, 16'(101 * recv)); end
            end
            @(posedge clk);
            if (tin) sent++;
            if (tout) recv++;
        end
        #1 bus.in_valid = 1'b0;
        n_chk++; if (recv !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", recv); end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_duplicate: got %0d extra outputs want 0", extra); end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.A = 16'h1000 + 16'(i); bus.B = 16'h0101; bus.C_in = 1'b0;
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #2;
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_fly_pre_valid: got %b want 1", bus.out_valid); end
        rst_n = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fly_out_valid: got %b want 0", bus.out_valid); end
        n_chk++; if (bus.S !== 16'h0) begin n_fail++; $display("FAIL rst_fly_S: got %h want 0000", bus.S); end
        n_chk++; if (bus.C_out !== 1'b0) begin n_fail++; $display("FAIL rst_fly_C_out: got %b want 0", bus.C_out); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL rst_fly_no_output: got %0d outputs want 0", seen); end
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fly_in_ready: got %b want 1", bus.in_ready); end
    endtask

`ifdef PIPE_RCA_SUB_EN
    task automatic test_sub();
        logic [15:0] s; logic co, v; int lat;
        bus.Sub = 1'b1;
        run_one(16'h0005, 16'h0007, 1'b0, s, co, v, lat);
        n_chk++; if (s !== 16'hFFFE) begin n_fail++; $display("FAIL sub_small_S: got %h want FFFE", s); end
        n_chk++; if (co !== 1'b0) begin n_fail++; $display("FAIL sub_small_C_out: got %b want 0", co); end
        n_chk++; if (v !== 1'b0) begin n_fail++; $display("FAIL sub_small_V: got %b want 0", v); end
        run_one(16'h8000, 16'h0001, 1'b0, s, co, v, lat);
        n_chk++; if (s !== 16'h7FFF) begin n_fail++; $display("FAIL sub_ovf_S: got %h want 7FFF", s); end
        n_chk++; if (co !== 1'b1) begin n_fail++; $display("FAIL sub_ovf_C_out: got %b want 1", co); end
        n_chk++; if (v !== 1'b1) begin n_fail++; $display("FAIL sub_ovf_V: got %b want 1", v); end
        bus.Sub = 1'b0;
    endtask
`endif

    task automatic test_random();
        localparam int NR = 3000;
        logic [17:0] exp_q[$];
        logic [17:0] e;
        logic [16:0] full;
        logic [15:0] bb;
        logic        cc, sb, v, tin, tout;
        int sent = 0, got = 0;
        for (int cyc = 0; cyc < 30000 && got < NR; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < NR) && ($urandom_range(0, 3) != 0);
            bus.A         = 16'($urandom);
            bus.B         = 16'($urandom);
            bus.C_in      = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            sb = 1'b0;
`ifdef PIPE_RCA_SUB_EN
            bus.Sub = 1'($urandom_range(0, 1));
            sb = bus.Sub;
`endif
            #1;
            n_chk++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready))
                begin n_fail++; $display("FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, bus.in_ready, !bus.out_valid || bus.out_ready); end
            tin  = bus.in_valid & bus.in_ready;
            tout = bus.out_valid & bus.out_ready;
            if (tin) begin
                bb   = sb ? ~bus.B : bus.B;
                cc   = sb ? ~bus.C_in : bus.C_in;
                full = {1'b0, bus.A} + {1'b0, bb} + {16'd0, cc};
                v    = (bus.A[15] == bb[15]) && (full[15] != bus.A[15]);
                exp_q.push_back({v, full});
            end
            if (tout) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_unexpected_output: got S=%h want no output", bus.S);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.V, bus.C_out, bus.S} !== e)
                        begin n_fail++; $display("FAIL rnd_result #%0d: got V=%b C=%b S=%h want V=%b C=%b S=%h", got, bus.V, bus.C_out, bus.S, e[17], e[16], e[15:0]); end
                end
            end
            @(posedge clk);
            if (tin) sent++;
            if (tout) got++;
        end
        #1 bus.in_valid = 1'b0;
        n_chk++; if (got !== NR) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got, NR); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_carry_wrap();
        test_overflow();
        test_back_to_back();
        test_reset_inflight();
`ifdef PIPE_RCA_SUB_EN
        test_sub();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
